fibonacci_multi_rate: RTL and testbench

Parametrised multi-rate Fibonacci generator. Each accepted beat presents LANES consecutive sequence terms, so one instance covers single-rate (LANES=1), double-rate (LANES=2) and wider use. Adds a valid/ready output handshake, synchronous restart, a lane-0 sequence index and a sticky overflow flag. Sits as a stimulus or reference source feeding downstream datapath blocks and testbench scoreboards.

---
 rtl/fibonacci_multi_rate.sv | 77 +++++++
 tb/tb_fibonacci_multi_rate.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fibonacci_multi_rate.sv
// fibonacci_multi_rate: Fibonacci source emitting LANES consecutive terms per accepted beat.
//   clk       - clock, all state changes on posedge
//   rst       - synchronous active-high reset
//   restart   - synchronous return to F(0), clears overflow
//   out_ready - consumer accepts the current beat
//   out_valid - num/index hold a valid beat
//   num       - lane k at [k*WIDTH +: WIDTH], lane 0 is the earliest term
//   index     - sequence index of lane 0, modulo 2^IDX_W
//   overflow  - sticky, set once an accepted beat held a wrapped term
module fibonacci_multi_rate #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int IDX_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] num,
    output logic [IDX_W-1:0]       index,
    output logic                   overflow
);
    logic [WIDTH-1:0] a, b;
    logic             wa, wb;
    logic [WIDTH-1:0] e [LANES+2];
    logic             w [LANES+2];
    logic [WIDTH:0]   s;
    logic             hit;
    // e[LANES] and e[LANES+1] seed the next beat; w marks terms derived from any wrapped add
    always_comb begin
        s = '0;
        e[0] = a;
        e[1] = b;
        w[0] = wa;
        w[1] = wb;
        for (int k = 2; k < LANES + 2; k++) begin
            s = {1'b0, e[k-1]} + {1'b0, e[k-2]};
            e[k] = s[WIDTH-1:0];
            w[k] = s[WIDTH] | w[k-1] | w[k-2];
        end
        num = '0;
        hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            num[k*WIDTH +: WIDTH] = e[k];
            hit = hit | w[k];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= WIDTH'(1);
            b         <= WIDTH'(1);
            wa        <= 1'b0;
            wb        <= 1'b0;
            index     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (restart) begin
                a        <= WIDTH'(1);
                b        <= WIDTH'(1);
                wa       <= 1'b0;
                wb       <= 1'b0;
                index    <= '0;
                overflow <= 1'b0;
            end else if (out_valid && out_ready) begin
                a     <= e[LANES];
                b     <= e[LANES+1];
                wa    <= w[LANES];
                wb    <= w[LANES+1];
                index <= index + IDX_W'(LANES);
                if (hit) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fibonacci_multi_rate.sv
// tb_fibonacci_multi_rate: 1/2/4-lane generators checked against a term-table model.
module tb_fibonacci_multi_rate;
    localparam int MAXN = 70000;
    logic        clk = 1'b0, rst = 1'b1, restart = 1'b0, ready = 1'b0;
    logic        v1, v2, v4, ov1, ov2, ov4;
    logic [15:0] num1, idx1, idx2, idx4;
    logic [31:0] num2;
    logic [63:0] num4;
    int          ft [MAXN];
    int          wrapn;
    int          mn [3];
    bit          mv [3];
    bit          mo [3];
    int          ln [3] = '{1, 2, 4};
    int          errors = 0, checks = 0;
    int          exp10 [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    always #5 clk = ~clk;
    fibonacci_multi_rate #(.WIDTH(16), .LANES(1), .IDX_W(16)) d1 (
        .clk(clk), .rst(rst), .restart(restart), .out_ready(ready),
        .out_valid(v1), .num(num1), .index(idx1), .overflow(ov1));
    fibonacci_multi_rate #(.WIDTH(16), .LANES(2), .IDX_W(16)) d2 (
        .clk(clk), .rst(rst), .restart(restart), .out_ready(ready),
        .out_valid(v2), .num(num2), .index(idx2), .overflow(ov2));
    fibonacci_multi_rate #(.WIDTH(16), .LANES(4), .IDX_W(16)) d4 (
        .clk(clk), .rst(rst), .restart(restart), .out_ready(ready),
        .out_valid(v4), .num(num4), .index(idx4), .overflow(ov4));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] lane(input int d, input int k);
        logic [63:0] all;
        all = d == 0 ? {48'b0, num1} : d == 1 ? {32'b0, num2} : num4;
        return all[k*16 +: 16];
    endfunction
    function automatic logic [15:0] gidx(input int d);
        return d == 0 ? idx1 : d == 1 ? idx2 : idx4;
    endfunction
    function automatic logic gv(input int d);
        return d == 0 ? v1 : d == 1 ? v2 : v4;
    endfunction
    function automatic logic gov(input int d);
        return d == 0 ? ov1 : d == 1 ? ov2 : ov4;
    endfunction
    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("valid_L%0d", ln[d]), 64'(gv(d)), 64'(mv[d]));
            check($sformatf("ovf_L%0d", ln[d]), 64'(gov(d)), 64'(mo[d]));
            if (mv[d]) begin
                check($sformatf("idx_L%0d", ln[d]), 64'(gidx(d)), 64'(mn[d] % 65536));
                for (int k = 0; k < ln[d]; k++)
                    check($sformatf("lane%0d_L%0d_n%0d", k, ln[d], mn[d] + k),
                          64'(lane(d, k)), 64'(ft[mn[d] + k]));
            end
        end
    endtask
    task automatic update();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mv[d] = 0;
                mn[d] = 0;
                mo[d] = 0;
            end else begin
                if (restart) begin
                    mn[d] = 0;
                    mo[d] = 0;
                end else if (mv[d] && ready) begin
                    if (mn[d] + ln[d] - 1 >= wrapn) mo[d] = 1;
                    mn[d] += ln[d];
                end
                mv[d] = 1;
            end
        end
    endtask
    task automatic step();
        check_all();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask
    initial begin
        longint ta, tb, tc;
        ft[0] = 1;
        ft[1] = 1;
        for (int i = 2; i < MAXN; i++) ft[i] = (ft[i-1] + ft[i-2]) % 65536;
        ta = 1;
        tb = 1;
        wrapn = 0;
        while (ta < 65536) begin
            tc = ta + tb;
            ta = tb;
            tb = tc;
            wrapn++;
        end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        update();
        @(negedge clk);
        step();
        check("rst_valid", 64'(v4), 0);
        check("rst_ovf", 64'(ov4), 0);
        rst = 0;
        ready = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("l1_seq%0d", i), 64'(num1), 64'(exp10[i]));
            check($sformatf("l1_idx%0d", i), 64'(idx1), 64'(i));
            if (i == 0) check("l2_beat0", 64'(num2), 64'h0001_0001);
            if (i == 1) check("l2_beat1", 64'(num2), 64'h0003_0002);
            if (i == 5) begin
                check("l4_beat5", num4, {16'd46368, 16'd28657, 16'd17711, 16'd10946});
                check("l4_beat5_idx", 64'(idx4), 20);
                check("l4_beat5_ovf", 64'(ov4), 0);
            end
            if (i == 6) begin
                check("l4_beat6", num4, {16'd55667, 16'd65346, 16'd55857, 16'd9489});
                check("l4_beat6_ovf", 64'(ov4), 0);
            end
            if (i >= 7) check($sformatf("l4_ovf_sticky%0d", i), 64'(ov4), 1);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            ready = (6'b101001 >> i) & 1'b1;
            step();
        end
        for (int r = 0; r < 2; r++) begin
            ready = 1;
            while (mn[2] <= wrapn + 4) step();
            check($sformatf("pre_restart_ovf%0d", r), 64'(ov4), 1);
            ready = r == 0;
            restart = 1;
            step();
            restart = 0;
            check($sformatf("restart_idx%0d", r), 64'(idx4), 0);
            check($sformatf("restart_num%0d", r), num4, 64'h0003_0002_0001_0001);
            check($sformatf("restart_ovf%0d", r), 64'(ov4), 0);
        end
        ready = 1;
        while (mn[2] < 12) step();
        check("mid_idx12", 64'(idx4), 12);
        rst = 1;
        step();
        check("mid_rst_valid", 64'(v4), 0);
        rst = 0;
        step();
        check("mid_rel_valid", 64'(v4), 1);
        check("mid_rel_num", num4, 64'h0003_0002_0001_0001);
        check("mid_rel_idx", 64'(idx4), 0);
        check("mid_rel_ovf", 64'(ov4), 0);
        for (int i = 0; i < 16384; i++) step();
        check("idx_wrap", 64'(idx4), 0);
        check("idx_wrap_num", 64'(num4[15:0]), 64'(ft[65536]));
        restart = 1;
        step();
        restart = 0;
        for (int i = 0; i < 3000; i++) begin
            ready = 1'($urandom_range(0, 1));
            rst = $urandom_range(0, 49) == 0;
            restart = $urandom_range(0, 19) == 0 || mn[2] > MAXN - 100;
            step();
        end
        rst = 0;
        restart = 0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
